// File: rtl/writeback_scheduler.sv
// -----------------------------------------------------------------------------
// writeback_scheduler
//
// Owns the single register-file write port behind the writeback stage. A
// shift-register reservation table tracks which future writeback cycles are
// already claimed. Each cycle at most one thread is granted issue, round-robin
// among threads whose instruction's writeback cycle is still free, so the
// single-cycle, memory and multi-cycle pipes never collide at writeback.
//
// Ports:
//   clk                    clock
//   reset                  asynchronous active-high reset
//   ts_request             per-thread: instruction ready to issue
//   ts_has_dest            per-thread: instruction writes a register
//   ts_latency_class       per-thread 2-bit class (0 scycle, 1 mem, 2 mcycle)
//   wb_rollback_en         rollback from the writeback stage
//   wb_rollback_thread_idx thread being rolled back
//   ws_grant               one-hot0 issue grant (combinational)
//   ws_conflict            a requester was blocked only by slot occupancy
//   ws_conflict_count      (WB_SCHED_PERF_EN only) count of conflict cycles
//
// Build option: define WB_SCHED_PERF_EN to add the ws_conflict_count output.
// -----------------------------------------------------------------------------
module writeback_scheduler #(
    parameter int NUM_THREADS    = 4,
    parameter int LATENCY_SCYCLE = 2,
    parameter int LATENCY_MEM    = 4,
    parameter int LATENCY_MCYCLE = 6,
    parameter int SLOT_DEPTH     = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_THREADS-1:0]         ts_request,
    input  logic [NUM_THREADS-1:0]         ts_has_dest,
    input  logic [2*NUM_THREADS-1:0]       ts_latency_class,
    input  logic                           wb_rollback_en,
    input  logic [$clog2(NUM_THREADS)-1:0] wb_rollback_thread_idx,
    output logic [NUM_THREADS-1:0]         ws_grant,
    output logic                           ws_conflict
`ifdef WB_SCHED_PERF_EN
    ,
    output logic [31:0]                    ws_conflict_count
`endif
);

    localparam int TW = $clog2(NUM_THREADS);
    localparam int SW = (SLOT_DEPTH > 1) ? $clog2(SLOT_DEPTH) : 1;

    typedef logic [TW-1:0] tid_t;
    typedef logic [SW-1:0] sidx_t;

    // Class 3 is illegal and flagged by an assertion; it falls back to the
    // single-cycle latency so the table index always stays in range.
    function automatic int latency_of(input logic [1:0] cls);
        case (cls)
            2'd1:    return LATENCY_MEM;
            2'd2:    return LATENCY_MCYCLE;
            default: return LATENCY_SCYCLE;
        endcase
    endfunction

    function automatic sidx_t slot_of(input logic [1:0] cls, input int offset);
        return sidx_t'(latency_of(cls) - offset);
    endfunction

    // Reservation table: res_valid[k] claims writeback at cycle t+k+1.
    logic [SLOT_DEPTH-1:0] res_valid, res_valid_nxt;
    tid_t                  res_thread     [SLOT_DEPTH];
    tid_t                  res_thread_nxt [SLOT_DEPTH];
    tid_t                  rr_ptr;

    logic [1:0]             cls [NUM_THREADS];
    logic [NUM_THREADS-1:0] rolled_back;
    logic [NUM_THREADS-1:0] slot_busy;
    logic [NUM_THREADS-1:0] eligible;
    logic [NUM_THREADS-1:0] blocked;

    logic grant_found;
    tid_t grant_idx;
    tid_t cand;

    for (genvar g = 0; g < NUM_THREADS; g++) begin : g_cls
        assign cls[g] = ts_latency_class[2*g +: 2];
    end

    // NOTE: every variable assigned in an always_comb gets a default at the
    // top of the block, so no path leaves it holding a value (no latch).
    always_comb begin
        rolled_back = '0;
        slot_busy   = '0;
        eligible    = '0;
        blocked     = '0;
        for (int n = 0; n < NUM_THREADS; n++) begin
            rolled_back[n] = wb_rollback_en && (wb_rollback_thread_idx == tid_t'(n));
            slot_busy[n]   = ts_has_dest[n] && res_valid[slot_of(cls[n], 1)];
            eligible[n]    = ts_request[n] && !rolled_back[n] && !slot_busy[n];
            blocked[n]     = ts_request[n] && !rolled_back[n] && slot_busy[n];
        end
    end

    assign ws_conflict = |blocked;

    // Round-robin scan starting one past the last granted thread; the
    // TW-bit add wraps naturally because NUM_THREADS is a power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_THREADS; i++) begin
            cand = rr_ptr + tid_t'(i);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign ws_grant = grant_found ? (NUM_THREADS'(1) << grant_idx) : '0;

    // Next table: shift toward slot 0, then drop the rolled-back thread's
    // entries, then insert the new reservation. Inserting at L-2 of the
    // shifted table is the same writeback cycle that L-1 named this cycle.
    always_comb begin
        for (int k = 0; k < SLOT_DEPTH - 1; k++) begin
            res_valid_nxt[k]  = res_valid[k+1];
            res_thread_nxt[k] = res_thread[k+1];
        end
        res_valid_nxt[SLOT_DEPTH-1]  = 1'b0;
        res_thread_nxt[SLOT_DEPTH-1] = '0;

        if (wb_rollback_en) begin
            for (int k = 0; k < SLOT_DEPTH; k++) begin
                if (res_thread_nxt[k] == wb_rollback_thread_idx) begin
                    res_valid_nxt[k] = 1'b0;
                end
            end
        end

        if (grant_found && ts_has_dest[grant_idx]) begin
            res_valid_nxt[slot_of(cls[grant_idx], 2)]  = 1'b1;
            res_thread_nxt[slot_of(cls[grant_idx], 2)] = grant_idx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid <= '0;
            // NOTE: the thread tags are reset too; they are a small flop
            // array, and a known value keeps rollback matching deterministic.
            for (int k = 0; k < SLOT_DEPTH; k++) begin
                res_thread[k] <= '0;
            end
            rr_ptr <= tid_t'(NUM_THREADS - 1);
        end else begin
            res_valid  <= res_valid_nxt;
            res_thread <= res_thread_nxt;
            if (grant_found) begin
                rr_ptr <= grant_idx;
            end
        end
    end

`ifdef WB_SCHED_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ws_conflict_count <= '0;
        end else if (ws_conflict) begin
            ws_conflict_count <= ws_conflict_count + 32'd1;
        end
    end
`endif

    // Simulation checks.
    localparam bit LATENCIES_OK =
        (LATENCY_SCYCLE >= 2) && (LATENCY_SCYCLE <= SLOT_DEPTH) &&
        (LATENCY_MEM    >= 2) && (LATENCY_MEM    <= SLOT_DEPTH) &&
        (LATENCY_MCYCLE >= 2) && (LATENCY_MCYCLE <= SLOT_DEPTH);

    a_latency_range: assert property (@(posedge clk) LATENCIES_OK);

    a_grant_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(ws_grant));

    for (genvar g = 0; g < NUM_THREADS; g++) begin : g_cls_chk
        a_no_class3: assert property (@(posedge clk) disable iff (reset)
            ts_request[g] |-> (cls[g] != 2'd3));
    end

endmodule

// File: tb/tb_writeback_scheduler.sv
// -----------------------------------------------------------------------------
// tb_writeback_scheduler
//
// Directed bench for writeback_scheduler. A reference model books writeback
// ownership by absolute cycle number and checks ws_grant / ws_conflict every
// cycle; directed scenarios also carry hand-computed literal expectations.
// Build option: WB_SCHED_PERF_EN adds the conflict-counter scenario.
// -----------------------------------------------------------------------------
module tb_writeback_scheduler;

    localparam int N    = 4;
    localparam int L_SC = 2;
    localparam int L_MM = 4;
    localparam int L_MC = 6;
    localparam int HORIZON = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] ts_request = '0;
    logic [3:0] ts_has_dest = '0;
    logic [7:0] ts_latency_class = '0;
    logic       wb_rollback_en = 1'b0;
    logic [1:0] wb_rollback_thread_idx = '0;
    logic [3:0] ws_grant;
    logic       ws_conflict;
`ifdef WB_SCHED_PERF_EN
    logic [31:0] ws_conflict_count;
`endif

    int tests = 0;
    int fails = 0;

    writeback_scheduler #(
        .NUM_THREADS(N), .LATENCY_SCYCLE(L_SC), .LATENCY_MEM(L_MM),
        .LATENCY_MCYCLE(L_MC), .SLOT_DEPTH(8)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .ts_request             (ts_request),
        .ts_has_dest            (ts_has_dest),
        .ts_latency_class       (ts_latency_class),
        .wb_rollback_en         (wb_rollback_en),
        .wb_rollback_thread_idx (wb_rollback_thread_idx),
        .ws_grant               (ws_grant),
        .ws_conflict            (ws_conflict)
`ifdef WB_SCHED_PERF_EN
        ,
        .ws_conflict_count      (ws_conflict_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // own_v/own_t[c % HORIZON]: writeback at absolute cycle c is claimed by thread own_t.
    bit own_v [HORIZON];
    int own_t [HORIZON];
    int mcyc = 0;
    int m_rr = N - 1;

    function automatic int lat_of(input logic [1:0] c);
        case (c)
            2'd1:    return L_MM;
            2'd2:    return L_MC;
            default: return L_SC;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [3:0] exp_grant;
        logic       exp_conf;
        logic [3:0] elig;
        int         g;
        #2;
        if (reset) begin
            for (int s = 0; s < HORIZON; s++) own_v[s] = 1'b0;
            m_rr = N - 1;
        end
        exp_grant = '0;
        exp_conf  = 1'b0;
        elig      = '0;
        g         = -1;
        for (int n = 0; n < N; n++) begin
            bit rb, busy;
            int wb_cyc;
            rb     = wb_rollback_en && (int'(wb_rollback_thread_idx) == n);
            wb_cyc = mcyc + lat_of(ts_latency_class[2*n +: 2]);
            busy   = ts_has_dest[n] && own_v[wb_cyc % HORIZON];
            elig[n] = ts_request[n] && !rb && !busy;
            if (ts_request[n] && !rb && busy) exp_conf = 1'b1;
        end
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (m_rr + i) % N;
            if (g < 0 && elig[c]) g = c;
        end
        if (g >= 0) exp_grant[g] = 1'b1;
        check("model_grant", {28'b0, ws_grant}, {28'b0, exp_grant});
        check("model_conflict", {31'b0, ws_conflict}, {31'b0, exp_conf});

        if (!reset) begin
            if (wb_rollback_en) begin
                for (int s = 0; s < HORIZON; s++)
                    if (own_v[s] && own_t[s] == int'(wb_rollback_thread_idx)) own_v[s] = 1'b0;
            end
            own_v[mcyc % HORIZON] = 1'b0;
            if (g >= 0) begin
                m_rr = g;
                if (ts_has_dest[g]) begin
                    int s;
                    s = (mcyc + lat_of(ts_latency_class[2*g +: 2])) % HORIZON;
                    own_v[s] = 1'b1;
                    own_t[s] = g;
                end
            end
            mcyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [3:0] r, input logic [3:0] d, input logic [7:0] c,
                         input logic rbe, input logic [1:0] rbi);
        @(negedge clk);
        ts_request             = r;
        ts_has_dest            = d;
        ts_latency_class       = c;
        wb_rollback_en         = rbe;
        wb_rollback_thread_idx = rbi;
    endtask

    task automatic expect_out(input string name, input logic [3:0] g, input logic c);
        #3;
        check({name, "_grant"}, {28'b0, ws_grant}, {28'b0, g});
        check({name, "_conflict"}, {31'b0, ws_conflict}, {31'b0, c});
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) drive(4'b0, 4'b0, 8'h00, 1'b0, 2'd0);
    endtask

    initial begin
        // Reset state.
        #3;
        check("reset_grant", {28'b0, ws_grant}, 32'd0);
        check("reset_conflict", {31'b0, ws_conflict}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(1);

        // Thread 0, mem, with dest, every cycle: granted each cycle.
        for (int i = 0; i < 6; i++) begin
            drive(4'b0001, 4'b0001, 8'b0000_0001, 1'b0, 2'd0);
            expect_out("t0_mem_stream", 4'b0001, 1'b0);
        end
        idle(8);

        // Thread 1 mem at t; thread 2 scycle blocked at t+2, granted at t+3.
        drive(4'b0010, 4'b0010, 8'b0000_0100, 1'b0, 2'd0);
        expect_out("t1_mem", 4'b0010, 1'b0);
        idle(1);
        drive(4'b0100, 4'b0100, 8'b0000_0000, 1'b0, 2'd0);
        expect_out("t2_blocked", 4'b0000, 1'b1);
        drive(4'b0100, 4'b0100, 8'b0000_0000, 1'b0, 2'd0);
        expect_out("t2_granted", 4'b0100, 1'b0);
        idle(8);

        // All threads, no dest: rotation continues from thread 3 and wraps.
        drive(4'b1111, 4'b0000, 8'h00, 1'b0, 2'd0);
        expect_out("rot0", 4'b1000, 1'b0);
        drive(4'b1111, 4'b0000, 8'h00, 1'b0, 2'd0);
        expect_out("rot1", 4'b0001, 1'b0);
        drive(4'b1111, 4'b0000, 8'h00, 1'b0, 2'd0);
        expect_out("rot2", 4'b0010, 1'b0);
        drive(4'b1111, 4'b0000, 8'h00, 1'b0, 2'd0);
        expect_out("rot3", 4'b0100, 1'b0);
        drive(4'b1111, 4'b0000, 8'h00, 1'b0, 2'd0);
        expect_out("rot4", 4'b1000, 1'b0);
        idle(2);

        // Thread 3 mcycle at t; rollback of 3 at t+1 while thread 0 mcycle wins.
        drive(4'b1000, 4'b1000, 8'b1000_0000, 1'b0, 2'd0);
        expect_out("t3_mcycle", 4'b1000, 1'b0);
        drive(4'b1001, 4'b1001, 8'b1000_0010, 1'b1, 2'd3);
        expect_out("rollback_cycle", 4'b0001, 1'b0);
        // Thread 3's old slot (now checked by a mem request) must be free.
        drive(4'b0010, 4'b0010, 8'b0000_0100, 1'b0, 2'd0);
        expect_out("slot_cleared", 4'b0010, 1'b0);
        idle(8);

        // Three reservations pending, then an asynchronous reset.
        drive(4'b0001, 4'b0001, 8'b0000_0010, 1'b0, 2'd0);
        expect_out("pend0", 4'b0001, 1'b0);
        drive(4'b0010, 4'b0010, 8'b0000_0100, 1'b0, 2'd0);
        expect_out("pend1", 4'b0010, 1'b0);
        drive(4'b0100, 4'b0100, 8'b0000_0000, 1'b0, 2'd0);
        expect_out("pend2", 4'b0100, 1'b0);
        drive(4'b0000, 4'b0000, 8'h00, 1'b0, 2'd0);
        reset = 1'b1;
        expect_out("in_reset", 4'b0000, 1'b0);
        drive(4'b1111, 4'b1111, 8'h00, 1'b0, 2'd0);
        reset = 1'b0;
        expect_out("post_reset", 4'b0001, 1'b0);
        drive(4'b1111, 4'b1111, 8'h00, 1'b0, 2'd0);
        expect_out("post_reset2", 4'b0010, 1'b0);
        idle(8);

`ifdef WB_SCHED_PERF_EN
        // Thread 0 books every future cycle; thread 1 scycle is blocked 5 times.
        drive(4'b0001, 4'b0001, 8'b0000_0001, 1'b0, 2'd0);
        drive(4'b0001, 4'b0001, 8'b0000_0001, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            drive(4'b0011, 4'b0011, 8'b0000_0001, 1'b0, 2'd0);
            expect_out("perf_conflict", 4'b0001, 1'b1);
        end
        drive(4'b0001, 4'b0001, 8'b0000_0001, 1'b0, 2'd0);
        #3;
        check("perf_count5", ws_conflict_count, 32'd5);
        force dut.ws_conflict_count = 32'hFFFF_FFFF;
        #1;
        release dut.ws_conflict_count;
        drive(4'b0011, 4'b0011, 8'b0000_0001, 1'b0, 2'd0);
        expect_out("perf_wrap_conflict", 4'b0001, 1'b1);
        drive(4'b0000, 4'b0000, 8'h00, 1'b0, 2'd0);
        #3;
        check("perf_wrap", ws_conflict_count, 32'd0);
        idle(8);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
